// File: rtl/pcpu_ctrl_pkg.sv
// Shared control encodings for the interrupt-capable 5-stage pipeline.
// Used by the sequencer here and by the ID_EX register-id fields.
package pcpu_ctrl_pkg;

    localparam int REG_W = 6;

    // Handler entry PC, applied by the PC mux when pc_sel selects PCSEL_INTR.
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_SERVICE = 2'b10,
        ST_RETURN  = 2'b11
    } state_t;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_INTR = 2'b10;
    localparam logic [1:0] PCSEL_EPC  = 2'b11;

endpackage

// File: rtl/pipe_hazard_intr_ctrl_hazard_detect.sv
// Load-use compare: a load in EX whose destination feeds the ID instruction.
// Register 0 never stalls since it is never really written.
module hazard_detect
    import pcpu_ctrl_pkg::*;
(
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    output logic             o_lu
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (i_ex_rt == i_id_rs);
    assign w_rt_hit = i_id_uses_rt && (i_ex_rt == i_id_rt);
    assign o_lu     = i_ex_memread && (i_ex_rt != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_intr_ctrl.sv
// Pipeline sequencer: stall/flush control plus the interrupt entry/return FSM.
//   state   | meaning
//   IDLE    | no interrupt pending
//   WAIT    | request seen, waiting for a real instruction in EX to restart from
//   SERVICE | handler running, requests masked, watching for eret
//   RETURN  | one masked cycle after eret before requests are honoured again
module pipe_hazard_intr_ctrl
    import pcpu_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_eret_id,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_ex_valid,
    input  logic [31:0]      i_ex_pc,
    input  logic             i_branch_taken,
    input  logic             i_intr_req,
    input  logic             i_ie,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_flush_if,
    output logic             o_cancel_id,
    output logic             o_cancel_ex,
    output logic [1:0]       o_pc_sel,
    output logic [31:0]      o_epc,
    output logic             o_epc_we,
    output logic             o_intr_ack,
    output logic             o_in_service
);

    state_t      r_state;
    logic [31:0] r_epc;
    logic        w_lu;
    logic        w_entry;
    logic        w_eret_go;

    hazard_detect u_hazard_detect (
        .i_ex_memread (i_ex_memread),
        .i_ex_rt      (i_ex_rt),
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_id_uses_rt (i_id_uses_rt),
        .o_lu         (w_lu)
    );

    // Entry needs a real EX instruction to restart from; a dropped request is not acked.
    assign w_entry   = (r_state == ST_WAIT) && i_intr_req && i_ex_valid
                       && !i_branch_taken && !w_lu;
    assign w_eret_go = (r_state == ST_SERVICE) && i_eret_id && !i_branch_taken && !w_lu;
    assign o_epc     = r_epc;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_epc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_intr_req && i_ie) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_entry) begin
                        r_state <= ST_SERVICE;
                        r_epc   <= i_ex_pc;
                    end else if (!i_intr_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (w_eret_go) r_state <= ST_RETURN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_flush_if   = 1'b0;
        o_cancel_id  = 1'b0;
        o_cancel_ex  = 1'b0;
        o_pc_sel     = PCSEL_SEQ;
        o_epc_we     = 1'b0;
        o_intr_ack   = 1'b0;
        o_in_service = (r_state == ST_SERVICE) || (r_state == ST_RETURN);
        if (!i_rst) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_flush_if   = 1'b1;
            o_cancel_id  = 1'b1;
            o_cancel_ex  = 1'b1;
            o_in_service = 1'b0;
        end else if (w_entry) begin
            o_pc_sel    = PCSEL_INTR;
            o_flush_if  = 1'b1;
            o_cancel_id = 1'b1;
            o_cancel_ex = 1'b1;
            o_epc_we    = 1'b1;
            o_intr_ack  = 1'b1;
        end else if (i_branch_taken) begin
            o_pc_sel    = PCSEL_BR;
            o_flush_if  = 1'b1;
            o_cancel_id = 1'b1;
        end else if (w_lu) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_cancel_id  = 1'b1;
        end else if (w_eret_go) begin
            o_pc_sel   = PCSEL_EPC;
            o_flush_if = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_intr_ctrl.sv
// Directed walk through the stall/branch/interrupt scenarios, then random traffic,
// every cycle compared against a behavioural model of the sequencer rules.
module tb_pipe_hazard_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, eret_id, ex_memread, ex_valid, branch_taken, intr_req, ie;
    logic [31:0] ex_pc;
    logic        pc_write, ifid_write, flush_if, cancel_id, cancel_ex, epc_we, intr_ack, in_service;
    logic [1:0]  pc_sel;
    logic [31:0] epc_o;

    int n_checks = 0;
    int n_fail   = 0;

    // model: which phase of the interrupt protocol we are in, plus saved EPC
    bit          m_pending, m_handler, m_masked_ret;
    logic [31:0] m_epc;

    always #5 clk = ~clk;

    pipe_hazard_intr_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(id_uses_rt), .i_eret_id(eret_id), .i_ex_memread(ex_memread),
        .i_ex_rt(ex_rt), .i_ex_valid(ex_valid), .i_ex_pc(ex_pc),
        .i_branch_taken(branch_taken), .i_intr_req(intr_req), .i_ie(ie),
        .o_pc_write(pc_write), .o_ifid_write(ifid_write), .o_flush_if(flush_if),
        .o_cancel_id(cancel_id), .o_cancel_ex(cancel_ex), .o_pc_sel(pc_sel),
        .o_epc(epc_o), .o_epc_we(epc_we), .o_intr_ack(intr_ack), .o_in_service(in_service)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        rst = 1'b1; id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; eret_id = 0;
        ex_memread = 0; ex_valid = 0; branch_taken = 0; intr_req = 0; ie = 0; ex_pc = 0;
    endtask

    // Evaluate one cycle at the falling edge, then advance the model over the rising edge.
    task automatic step(input string tag);
        bit lu, entry, eret_go, e_pw, e_iw, e_fi, e_ci, e_ce, e_we, e_ack, e_svc;
        bit n_pend, n_hand, n_ret;
        logic [1:0]  e_sel;
        logic [31:0] n_epc;
        @(negedge clk);
        lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        entry   = m_pending && intr_req && ex_valid && !branch_taken && !lu;
        eret_go = m_handler && eret_id && !branch_taken && !lu;
        e_pw = 1; e_iw = 1; e_fi = 0; e_ci = 0; e_ce = 0; e_we = 0; e_ack = 0;
        e_sel = 2'd0; e_svc = m_handler || m_masked_ret;
        if (!rst) begin
            e_pw = 0; e_iw = 0; e_fi = 1; e_ci = 1; e_ce = 1; e_svc = 0;
        end else if (entry) begin
            e_sel = 2'd2; e_fi = 1; e_ci = 1; e_ce = 1; e_we = 1; e_ack = 1;
        end else if (branch_taken) begin
            e_sel = 2'd1; e_fi = 1; e_ci = 1;
        end else if (lu) begin
            e_pw = 0; e_iw = 0; e_ci = 1;
        end else if (eret_go) begin
            e_sel = 2'd3; e_fi = 1;
        end
        chk({tag, ".pc_write"},   {31'd0, pc_write},   {31'd0, e_pw});
        chk({tag, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, e_iw});
        chk({tag, ".flush_if"},   {31'd0, flush_if},   {31'd0, e_fi});
        chk({tag, ".cancel_id"},  {31'd0, cancel_id},  {31'd0, e_ci});
        chk({tag, ".cancel_ex"},  {31'd0, cancel_ex},  {31'd0, e_ce});
        chk({tag, ".pc_sel"},     {30'd0, pc_sel},     {30'd0, e_sel});
        chk({tag, ".epc_we"},     {31'd0, epc_we},     {31'd0, e_we});
        chk({tag, ".intr_ack"},   {31'd0, intr_ack},   {31'd0, e_ack});
        chk({tag, ".in_service"}, {31'd0, in_service}, {31'd0, e_svc});
        chk({tag, ".epc_o"},      epc_o,               m_epc);
        n_pend = 0; n_hand = 0; n_ret = 0; n_epc = m_epc;
        if (!rst) begin
            n_epc = 0;
        end else if (m_masked_ret) begin
            n_ret = 0;
        end else if (m_handler) begin
            if (eret_go) n_ret = 1; else n_hand = 1;
        end else if (m_pending) begin
            if (entry) begin n_hand = 1; n_epc = ex_pc; end
            else n_pend = intr_req;
        end else begin
            n_pend = intr_req && ie;
        end
        @(posedge clk);
        m_pending = n_pend; m_handler = n_hand; m_masked_ret = n_ret; m_epc = n_epc;
        #1;
    endtask

    initial begin
        m_pending = 0; m_handler = 0; m_masked_ret = 0; m_epc = 0;
        quiet();
        rst = 0;
        step("rst_a");
        step("rst_b");
        rst = 1;
        step("default");
        ex_memread = 1; ex_rt = 2; id_rs = 2;
        step("lu_rs");
        quiet();
        step("lu_one_bubble");
        ex_memread = 1; ex_rt = 0; id_rs = 0;
        step("lu_r0");
        ex_memread = 1; ex_rt = 5; id_rt = 5; id_uses_rt = 1; id_rs = 1;
        step("lu_rt");
        id_uses_rt = 0;
        step("lu_rt_unused");
        ex_rt = 2; id_rs = 2; branch_taken = 1;
        step("br_over_lu");
        quiet();
        intr_req = 1; ie = 1; ex_valid = 1; ex_pc = 32'h40;
        step("intr_idle");
        step("intr_entry");
        chk("epc_after_entry", epc_o, 32'h40);
        intr_req = 0; ex_valid = 0;
        step("service");
        eret_id = 1; branch_taken = 1;
        step("eret_held_br");
        branch_taken = 0;
        step("eret_go");
        eret_id = 0; intr_req = 1; ie = 1;
        step("return_masked");
        step("idle_after_ret");
        for (int i = 0; i < 3; i++) begin
            ex_pc = 32'h80 + 32'(i * 4);
            step("bubble_wait");
        end
        ex_valid = 1; ex_pc = 32'h100;
        step("entry_deferred");
        chk("epc_deferred", epc_o, 32'h100);
        intr_req = 0; ex_valid = 0;
        step("service2");
        rst = 0;
        step("rst_in_service");
        step("rst_held");
        chk("epc_cleared", epc_o, 32'h0);
        rst = 1;
        step("post_rst");

        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) != 0);
            id_rs        = 6'($urandom_range(0, 3));
            id_rt        = 6'($urandom_range(0, 3));
            ex_rt        = ($urandom_range(0, 15) == 0) ? 6'h21 : 6'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_memread   = ($urandom_range(0, 9) < 4);
            ex_valid     = ($urandom_range(0, 9) < 7);
            ex_pc        = {$urandom} & 32'hFFFF_FFFC;
            branch_taken = ($urandom_range(0, 19) < 3);
            eret_id      = ($urandom_range(0, 4) == 0);
            intr_req     = ($urandom_range(0, 9) < 4);
            ie           = ($urandom_range(0, 9) < 7);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
